sram_cycle_ctrl: RTL and testbench
==================================

SRAM_CYCLE_CTRL -- requirements
Module: sram_cycle_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 16: SRAM data width, a multiple of 8.
REQ-003 SHALL have parameter RD_WAIT, default 1: extra read-strobe cycles, range 0..15.
REQ-004 SHALL have parameter WR_WAIT, default 1: extra WE-low cycles, range 0..15.
REQ-005 SHALL have parameter TURN_CYC, default 1: bus-idle cycles on a read-to-write change, range 0..7.
REQ-006 SHALL have one clock and an asynchronous, active-high reset, as the following ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
REQ-007 SHALL have the host-side ports:
- REQ  in  1  request
- WR  in  1  1=write, 0=read
- ADDR  in  ADDR_W
- WDATA  in  DATA_W
- BE  in  DATA_W/8  byte enables, active-high
- WR_ALLOW  in  1  writes permitted (vector-apply phase)
- READY  out  1
- RDATA  out  DATA_W
- RVALID  out  1
- WDONE  out  1
- WR_ERR  out  1
REQ-008 SHALL have the SRAM-side ports:
- SRAM_ADDR  out  ADDR_W
- DQ_O  out  DATA_W
- DQ_I  in  DATA_W
- DQ_OE  out  1  tristate drive enable
- CS_BAR  out  1
- OE_BAR  out  1
- WE_BAR  out  1
- BE_BAR  out  DATA_W/8  byte-lane enables, active-low

Function
REQ-009 All SRAM-side outputs SHALL be registered; strobes SHALL be glitch-free.
REQ-010 FSM states SHALL be IDLE, TURN, RD, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-011 READY SHALL be high only in IDLE; a request is accepted on a clock edge where REQ && READY; ADDR/WR/WDATA/BE are captured at acceptance.
REQ-012 Read: RD SHALL last RD_WAIT+1 cycles with CS_BAR=0, OE_BAR=0, DQ_OE=0; DQ_I is registered into RDATA on the final RD edge; RVALID is high for one cycle as the FSM enters IDLE (latency RD_WAIT+2 from acceptance).
REQ-013 Write: the write sequence SHALL be:
- WR_SETUP: 1 cycle, CS_BAR=0, WE_BAR=1, DQ_OE=1
- WR_PULSE: WR_WAIT+1 cycles, WE_BAR=0
- WR_HOLD: 1 cycle, WE_BAR=1, CS_BAR=0, DQ still driven
- WDONE: one-cycle pulse on entry to IDLE
REQ-014 OE_BAR SHALL be 1 in every write state; DQ_OE SHALL be 1 only in write states.
REQ-015 A write accepted when the last completed operation was a read SHALL pass through TURN for TURN_CYC cycles (all strobes high, DQ_OE=0) before WR_SETUP; TURN_CYC=0 skips TURN.
REQ-016 Read-after-read, read-after-write and write-after-write SHALL insert no idle cycles beyond a single IDLE cycle.
REQ-017 A write accepted while WR_ALLOW=0 SHALL assert no strobe, SHALL pulse WR_ERR for one cycle on the next cycle, and the FSM SHALL remain in IDLE.
REQ-018 REQ while READY=0 SHALL be ignored, with no queuing.
REQ-019 RVALID, WDONE and WR_ERR SHALL be mutually exclusive in any cycle.

Reset
REQ-020 On RST=1, without a clock edge, the outputs SHALL take:
- CS_BAR, OE_BAR, WE_BAR = 1
- BE_BAR = all ones
- DQ_OE = 0
- RVALID, WDONE, WR_ERR = 0
- RDATA = 0, SRAM_ADDR = 0, DQ_O = 0
- FSM = IDLE, last-op flag = write
REQ-021 RST asserted mid-cycle SHALL abort the operation with no completion pulse; READY SHALL be high on the first edge after release.

Configuration
REQ-022 With SRAM_BYTE_LANE_EN defined, BE_BAR SHALL equal ~BE captured at acceptance and be asserted during RD/WR_SETUP/WR_PULSE/WR_HOLD.
REQ-023 Without SRAM_BYTE_LANE_EN, BE is ignored and BE_BAR SHALL be all zeros whenever CS_BAR=0 (full-word access).

Structure
REQ-024 Package sram_ctrl_pkg SHALL hold the FSM state enum, the default parameter values and the wait-counter width constant (4 bits).
REQ-025 Sub-module sram_wait_counter SHALL implement the loadable down-counter shared by RD, WR_PULSE and TURN, with a zero flag.

Verification
REQ-026 Read at ADDR=0x1234, RD_WAIT=1, SRAM model returning 0xBEEF -> OE_BAR low exactly 2 cycles; RDATA=0xBEEF with RVALID at acceptance+3.
REQ-027 Write of 0xA5A5 to 0x0010, WR_WAIT=2, WR_ALLOW=1 -> WE_BAR low exactly 3 cycles; DQ_O stable from WR_SETUP through WR_HOLD; WDONE at acceptance+6.
REQ-028 Read then immediate write, TURN_CYC=2 -> 2 cycles of all strobes high with DQ_OE=0 between OE_BAR rising and DQ_OE rising.
REQ-029 Write with WR_ALLOW=0 -> WE_BAR and CS_BAR never low; WR_ERR one cycle; READY stays high.
REQ-030 RST pulse during WR_PULSE -> WE_BAR/CS_BAR high asynchronously; no WDONE; the next read completes normally.
REQ-031 With SRAM_BYTE_LANE_EN, write with BE=2'b01 -> BE_BAR=2'b10 during the cycle; without the macro, BE_BAR=2'b00.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM cycle controller: default parameter values,
// wait-counter width and the bus-cycle FSM state encoding.
package sram_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_RD_WAIT  = 1;
    localparam int unsigned DEF_WR_WAIT  = 1;
    localparam int unsigned DEF_TURN_CYC = 1;

    // Wide enough for RD_WAIT/WR_WAIT up to 15 and TURN_CYC up to 7
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
    } state_t;

    // Chip select is active for every state that touches the SRAM
    function automatic logic cs_active(input state_t s);
        return (s == S_RD) || (s == S_WR_SETUP) || (s == S_WR_PULSE) || (s == S_WR_HOLD);
    endfunction

    // The data bus is driven only while a write is in progress
    function automatic logic dq_drive(input state_t s);
        return (s == S_WR_SETUP) || (s == S_WR_PULSE) || (s == S_WR_HOLD);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing the RD, WR_PULSE and TURN phases.
// zero is high when the count has reached 0; decrementing stops there.
module sram_wait_counter
    import sram_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] cnt;

    // Load takes priority over decrement; the count saturates at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - WAIT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sram_cycle_ctrl.sv
// Asynchronous SRAM bus-cycle controller. Sequences single read and write
// accesses with programmable wait states and a read-to-write bus turnaround.
// All SRAM-side outputs come straight from flops.
// Optional feature: define SRAM_BYTE_LANE_EN to drive BE_BAR from the
// captured byte enables; otherwise every access is full-word.
module sram_cycle_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned RD_WAIT  = DEF_RD_WAIT,
    parameter int unsigned WR_WAIT  = DEF_WR_WAIT,
    parameter int unsigned TURN_CYC = DEF_TURN_CYC
) (
    input  logic                CLK,
    input  logic                RST,
    // host side
    input  logic                REQ,
    input  logic                WR,
    input  logic [ADDR_W-1:0]   ADDR,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] BE,
    input  logic                WR_ALLOW,
    output logic                READY,
    output logic [DATA_W-1:0]   RDATA,
    output logic                RVALID,
    output logic                WDONE,
    output logic                WR_ERR,
    // SRAM side
    output logic [ADDR_W-1:0]   SRAM_ADDR,
    output logic [DATA_W-1:0]   DQ_O,
    input  logic [DATA_W-1:0]   DQ_I,
    output logic                DQ_OE,
    output logic                CS_BAR,
    output logic                OE_BAR,
    output logic                WE_BAR,
    output logic [DATA_W/8-1:0] BE_BAR
);

    localparam int unsigned BE_W = DATA_W / 8;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              accept_wr;
    logic              last_rd;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic [WAIT_W-1:0] cnt_load_val;
    logic              rvalid_next;
    logic              wdone_next;
    logic              wr_err_next;
    logic [BE_W-1:0]   lane_bar;

    assign READY = (state == S_IDLE);

    sram_wait_counter u_wait (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, wait-counter control and completion pulses
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        accept_wr    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        rvalid_next  = 1'b0;
        wdone_next   = 1'b0;
        wr_err_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (REQ) begin
                    if (!WR) begin
                        accept       = 1'b1;
                        state_next   = S_RD;
                        cnt_load     = 1'b1;
                        cnt_load_val = WAIT_W'(RD_WAIT);
                    end else if (WR_ALLOW) begin
                        accept    = 1'b1;
                        accept_wr = 1'b1;
                        if (last_rd && (TURN_CYC != 0)) begin
                            state_next   = S_TURN;
                            cnt_load     = 1'b1;
                            cnt_load_val = WAIT_W'(TURN_CYC - 1);
                        end else begin
                            state_next = S_WR_SETUP;
                        end
                    end else begin
                        wr_err_next = 1'b1;
                    end
                end
            end
            S_TURN: begin
                if (cnt_zero) begin
                    state_next = S_WR_SETUP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_RD: begin
                if (cnt_zero) begin
                    state_next  = S_IDLE;
                    rvalid_next = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_WR_SETUP: begin
                state_next   = S_WR_PULSE;
                cnt_load     = 1'b1;
                cnt_load_val = WAIT_W'(WR_WAIT);
            end
            S_WR_PULSE: begin
                if (cnt_zero) begin
                    state_next = S_WR_HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_WR_HOLD: begin
                state_next = S_IDLE;
                wdone_next = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Remember the direction of the last completed access for turnaround
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_rd <= 1'b0;
        end else if (rvalid_next) begin
            last_rd <= 1'b1;
        end else if (wdone_next) begin
            last_rd <= 1'b0;
        end
    end

`ifdef SRAM_BYTE_LANE_EN
    logic [BE_W-1:0] be_q;

    // Hold the byte enables of the accepted request for the whole access
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            be_q <= '0;
        end else if (accept) begin
            be_q <= BE;
        end
    end

    // Use the live BE on the acceptance edge so lanes are right from cycle one
    always_comb begin
        lane_bar = accept ? ~BE : ~be_q;
    end
`else
    logic unused_be;

    assign unused_be = ^BE;

    // Full-word accesses: all lanes enabled while selected
    always_comb begin
        lane_bar = '0;
    end
`endif

    // Registered SRAM strobes and host-side result outputs, decoded from the
    // next state so each strobe lines up with the state it belongs to
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CS_BAR    <= 1'b1;
            OE_BAR    <= 1'b1;
            WE_BAR    <= 1'b1;
            BE_BAR    <= '1;
            DQ_OE     <= 1'b0;
            RVALID    <= 1'b0;
            WDONE     <= 1'b0;
            WR_ERR    <= 1'b0;
            RDATA     <= '0;
            SRAM_ADDR <= '0;
            DQ_O      <= '0;
        end else begin
            CS_BAR <= !cs_active(state_next);
            OE_BAR <= (state_next != S_RD);
            WE_BAR <= (state_next != S_WR_PULSE);
            DQ_OE  <= dq_drive(state_next);
            BE_BAR <= cs_active(state_next) ? lane_bar : '1;
            RVALID <= rvalid_next;
            WDONE  <= wdone_next;
            WR_ERR <= wr_err_next;
            if (accept) begin
                SRAM_ADDR <= ADDR;
            end
            if (accept_wr) begin
                DQ_O <= WDATA;
            end
            if (rvalid_next) begin
                RDATA <= DQ_I;
            end
        end
    end

endmodule

// File: tb/tb_sram_cycle_ctrl.sv
// Self-checking bench for sram_cycle_ctrl: directed table, hand-written
// corner sequences (byte lanes, reset abort) and randomized traffic checked
// against a transaction-level reference model.
module tb_sram_cycle_ctrl;

    localparam int unsigned RD_W  = 1;
    localparam int unsigned WR_W  = 2;
    localparam int unsigned TRN_C = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ = 1'b0;
    logic        WR = 1'b0;
    logic [15:0] ADDR = '0;
    logic [15:0] WDATA = '0;
    logic [1:0]  BE = 2'b11;
    logic        WR_ALLOW = 1'b0;
    logic        READY;
    logic [15:0] RDATA;
    logic        RVALID;
    logic        WDONE;
    logic        WR_ERR;
    logic [15:0] SRAM_ADDR;
    logic [15:0] DQ_O;
    logic [15:0] DQ_I;
    logic        DQ_OE;
    logic        CS_BAR;
    logic        OE_BAR;
    logic        WE_BAR;
    logic [1:0]  BE_BAR;

    sram_cycle_ctrl #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .RD_WAIT  (RD_W),
        .WR_WAIT  (WR_W),
        .TURN_CYC (TRN_C)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .WR        (WR),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .BE        (BE),
        .WR_ALLOW  (WR_ALLOW),
        .READY     (READY),
        .RDATA     (RDATA),
        .RVALID    (RVALID),
        .WDONE     (WDONE),
        .WR_ERR    (WR_ERR),
        .SRAM_ADDR (SRAM_ADDR),
        .DQ_O      (DQ_O),
        .DQ_I      (DQ_I),
        .DQ_OE     (DQ_OE),
        .CS_BAR    (CS_BAR),
        .OE_BAR    (OE_BAR),
        .WE_BAR    (WE_BAR),
        .BE_BAR    (BE_BAR)
    );

    always #5 CLK = ~CLK;

    // Pin-level SRAM model: latches data while selected with WE low
    logic [15:0] sram [0:65535];
    logic        mem_init = 1'b1;

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 65536; i++) sram[i] <= '0;
            sram[16'h1234] <= 16'hBEEF;
        end else if (!CS_BAR && !WE_BAR && DQ_OE) begin
            if (!BE_BAR[0]) sram[SRAM_ADDR][7:0]  <= DQ_O[7:0];
            if (!BE_BAR[1]) sram[SRAM_ADDR][15:8] <= DQ_O[15:8];
        end
    end

    assign DQ_I = sram[SRAM_ADDR];

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic        allow;
    } op_t;

    // lat: cycles from the acceptance cycle to the completion/error pulse
    typedef struct {
        int          lat;
        logic [15:0] rdata;
        int          turn;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t ex;
    } vec_t;

    typedef struct {
        int          lat;
        int          pulses;
        logic [15:0] rdata;
        int          oe_low;
        int          we_low;
        int          turn;
        logic        dq_seen;
        logic [15:0] dq_first;
        logic        dq_stable;
        logic        be_ok;
        logic [1:0]  be_seen;
        logic        cs_low;
        logic        ready_low;
        logic        excl_ok;
    } obs_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_op  = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL op%0d %s: got 0x%0h, expected 0x%0h", cur_op, name, act, req);
        end
    endtask

    function automatic logic [1:0] exp_bebar(input logic [1:0] be);
`ifdef SRAM_BYTE_LANE_EN
        return ~be;
`else
        return 2'b00;
`endif
    endfunction

    // ---------------- reference model (transaction level) ----------------
    logic [15:0] ref_mem [logic [15:0]];
    logic        model_last_rd = 1'b0;

    function automatic logic [15:0] model_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    function automatic exp_t model_predict(input op_t op);
        exp_t e;
        e.rdata = '0;
        e.turn  = 0;
        if (!op.wr) begin
            e.lat   = RD_W + 2;
            e.rdata = model_read(op.addr);
        end else if (!op.allow) begin
            e.lat = 1;
        end else begin
            e.turn = model_last_rd ? TRN_C : 0;
            // turnaround + setup + pulse + hold, then the IDLE entry cycle
            e.lat  = e.turn + 1 + (WR_W + 1) + 1 + 1;
        end
        return e;
    endfunction

    task automatic model_update(input op_t op);
        logic [15:0] w;
        if (!op.wr) begin
            model_last_rd = 1'b1;
        end else if (op.allow) begin
            w = model_read(op.addr);
`ifdef SRAM_BYTE_LANE_EN
            if (op.be[0]) w[7:0]  = op.wdata[7:0];
            if (op.be[1]) w[15:8] = op.wdata[15:8];
`else
            w = op.wdata;
`endif
            ref_mem[op.addr] = w;
            model_last_rd = 1'b0;
        end
    endtask

    // ---------------- driver / monitor ----------------
    // Called at a negedge; issues the op as soon as READY and observes it
    task automatic do_op(input op_t op, output obs_t o);
        int wait_cnt;
        o.lat = 0; o.pulses = 0; o.rdata = '0; o.oe_low = 0; o.we_low = 0;
        o.turn = 0; o.dq_seen = 1'b0; o.dq_first = '0; o.dq_stable = 1'b1;
        o.be_ok = 1'b1; o.be_seen = 2'b11; o.cs_low = 1'b0; o.ready_low = 1'b0;
        o.excl_ok = 1'b1;
        wait_cnt = 0;
        while (!READY && wait_cnt < 50) begin
            @(negedge CLK);
            wait_cnt++;
        end
        if (!READY) begin
            o.lat = -1;
            return;
        end
        REQ = 1'b1; WR = op.wr; ADDR = op.addr; WDATA = op.wdata;
        BE = op.be; WR_ALLOW = op.allow;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                // scramble the host bus so only captured values can be used
                REQ = 1'b0;
                WR = 1'($urandom_range(0, 1));
                ADDR = 16'($urandom);
                WDATA = 16'($urandom);
                BE = 2'($urandom);
            end
            if (RVALID || WDONE || WR_ERR) begin
                o.pulses++;
                if (o.lat == 0) begin
                    o.lat   = k;
                    o.rdata = RDATA;
                end
            end
            if ((32'(RVALID) + 32'(WDONE) + 32'(WR_ERR)) > 1) o.excl_ok = 1'b0;
            if (!OE_BAR) o.oe_low++;
            if (!WE_BAR) o.we_low++;
            if (!READY) o.ready_low = 1'b1;
            if (!CS_BAR) begin
                o.cs_low  = 1'b1;
                o.be_seen = BE_BAR;
                if (BE_BAR !== exp_bebar(op.be)) o.be_ok = 1'b0;
            end
            if (DQ_OE) begin
                if (!o.dq_seen) begin
                    o.dq_seen  = 1'b1;
                    o.dq_first = DQ_O;
                end else if (DQ_O !== o.dq_first) begin
                    o.dq_stable = 1'b0;
                end
            end else if (!o.dq_seen && CS_BAR && OE_BAR && WE_BAR) begin
                o.turn++;
            end
            if (op.wr && !op.allow) begin
                if (k == 3) break;
            end else if (RVALID || WDONE) begin
                break;
            end
        end
    endtask

    task automatic check_op(input op_t op, input exp_t e, input obs_t o);
        chk("latency", o.lat, e.lat);
        chk("pulse_count", o.pulses, 1);
        chk("pulse_exclusive", o.excl_ok, 1);
        chk("be_bar_lanes", o.be_ok, 1);
        if (!op.wr) begin
            chk("rdata", o.rdata, e.rdata);
            chk("oe_low_cycles", o.oe_low, RD_W + 1);
            chk("read_we_high", o.we_low, 0);
        end else if (op.allow) begin
            chk("we_low_cycles", o.we_low, WR_W + 1);
            chk("write_oe_high", o.oe_low, 0);
            chk("turn_cycles", o.turn, e.turn);
            chk("dq_stable", o.dq_stable, 1);
            chk("dq_value", o.dq_first, op.wdata);
        end else begin
            chk("err_no_cs", o.cs_low, 0);
            chk("err_no_we", o.we_low, 0);
            chk("err_ready_high", o.ready_low, 0);
        end
    endtask

    task automatic run_model_op(input op_t op, output obs_t o);
        exp_t e;
        e = model_predict(op);
        do_op(op, o);
        check_op(op, e, o);
        model_update(op);
        cur_op++;
    endtask

    function automatic vec_t mkv(input logic wr, input logic [15:0] a, input logic [15:0] d,
                                 input logic allow, input int lat, input logic [15:0] rd,
                                 input int turn);
        vec_t v;
        v.op.wr = wr; v.op.addr = a; v.op.wdata = d; v.op.be = 2'b11; v.op.allow = allow;
        v.ex.lat = lat; v.ex.rdata = rd; v.ex.turn = turn;
        return v;
    endfunction

    vec_t tbl [11];

    initial begin
        obs_t o;
        op_t  op;
        logic saw_wdone;

        // Expected values for RD_WAIT=1, WR_WAIT=2, TURN_CYC=2
        tbl[0]  = mkv(1'b1, 16'h0010, 16'hA5A5, 1'b1, 6, 16'h0000, 0);
        tbl[1]  = mkv(1'b0, 16'h1234, 16'h0000, 1'b1, 3, 16'hBEEF, 0);
        tbl[2]  = mkv(1'b1, 16'h0020, 16'h5A5A, 1'b1, 8, 16'h0000, 2);
        tbl[3]  = mkv(1'b1, 16'h0030, 16'h1111, 1'b0, 1, 16'h0000, 0);
        tbl[4]  = mkv(1'b0, 16'h0010, 16'h0000, 1'b1, 3, 16'hA5A5, 0);
        tbl[5]  = mkv(1'b0, 16'h0030, 16'h0000, 1'b1, 3, 16'h0000, 0);
        tbl[6]  = mkv(1'b1, 16'h0040, 16'h2222, 1'b0, 1, 16'h0000, 0);
        tbl[7]  = mkv(1'b1, 16'h0040, 16'h2222, 1'b1, 8, 16'h0000, 2);
        tbl[8]  = mkv(1'b1, 16'h0050, 16'h3333, 1'b1, 6, 16'h0000, 0);
        tbl[9]  = mkv(1'b0, 16'h0040, 16'h0000, 1'b1, 3, 16'h2222, 0);
        tbl[10] = mkv(1'b0, 16'h0020, 16'h0000, 1'b1, 3, 16'h5A5A, 0);

        // Asynchronous reset values, checked before any clock edge
        #1 RST = 1'b1;
        #2;
        chk("reset_state",
            {CS_BAR, OE_BAR, WE_BAR, BE_BAR, DQ_OE, RVALID, WDONE, WR_ERR,
             RDATA, SRAM_ADDR, DQ_O, READY},
            {3'b111, 2'b11, 1'b0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1});
        repeat (3) @(negedge CLK);
        mem_init = 1'b0;
        RST = 1'b0;
        @(negedge CLK);

        // Directed table, issued back to back
        foreach (tbl[i]) begin
            do_op(tbl[i].op, o);
            check_op(tbl[i].op, tbl[i].ex, o);
            model_update(tbl[i].op);
            cur_op++;
        end

        // Partial byte-enable write following a read, then read it back
        op = '{wr: 1'b1, addr: 16'h0060, wdata: 16'hABCD, be: 2'b01, allow: 1'b1};
        run_model_op(op, o);
        chk("be01_lanes", o.be_seen, exp_bebar(2'b01));
        op = '{wr: 1'b0, addr: 16'h0060, wdata: 16'h0000, be: 2'b11, allow: 1'b1};
        run_model_op(op, o);

        // Reset in the middle of WR_PULSE aborts the write without WDONE
        REQ = 1'b1; WR = 1'b1; ADDR = 16'h0070; WDATA = 16'h7777; BE = 2'b11; WR_ALLOW = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (k == 1) REQ = 1'b0;
            if (!WE_BAR) break;
        end
        chk("rst_reached_pulse", WE_BAR, 0);
        #2 RST = 1'b1;
        #1;
        chk("rst_async_strobes", {CS_BAR, OE_BAR, WE_BAR, DQ_OE}, 4'b1110);
        chk("rst_async_pulses", {RVALID, WDONE, WR_ERR}, 3'b000);
        saw_wdone = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            if (WDONE) saw_wdone = 1'b1;
        end
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_ready_after_release", READY, 1);
        repeat (5) begin
            @(negedge CLK);
            if (WDONE) saw_wdone = 1'b1;
        end
        chk("rst_no_wdone", saw_wdone, 0);
        model_last_rd = 1'b0;
        cur_op++;
        op = '{wr: 1'b0, addr: 16'h0010, wdata: 16'h0000, be: 2'b11, allow: 1'b1};
        run_model_op(op, o);

        // Randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            op.wr    = 1'($urandom_range(0, 1));
            op.addr  = 16'h0100 + 16'($urandom_range(0, 15));
            op.wdata = 16'($urandom);
            op.be    = 2'($urandom_range(1, 3));
            op.allow = ($urandom_range(0, 5) != 0);
            run_model_op(op, o);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
